meta_drop_fifo: RTL and testbench
=================================

META_DROP_FIFO -- requirements
Module: meta_drop_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, minimum 2.
REQ-002 SHALL have parameter CNT_W, default 32, statistics counter width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port in_meta_data  input  metadata_t  metadata from the flow director, pkt_flags already set.
REQ-006 SHALL have port in_meta_valid  input  1  input metadata valid.
REQ-007 SHALL have port in_meta_ready  output  1  block can accept input.
REQ-008 SHALL have port out_meta_data  output  metadata_t  head-of-queue metadata toward PCIe.
REQ-009 SHALL have port out_meta_valid  output  1  head valid.
REQ-010 SHALL have port out_meta_ready  input  1  downstream accepts head.
REQ-011 SHALL have port occupancy  output  $clog2(DEPTH)+1  stored entry count.
REQ-012 SHALL have port stats_clr  input  1  clear statistics counters.
REQ-013 SHALL have port stats_pass_cnt  output  CNT_W  entries forwarded to the FIFO.
REQ-014 SHALL have port stats_drop_cnt  output  CNT_W  entries discarded.

Function
REQ-015 SHALL treat an input transfer as in_meta_valid && in_meta_ready in the same cycle, and an output transfer as out_meta_valid && out_meta_ready.
REQ-016 SHALL drive in_meta_ready = (occupancy != DEPTH), independent of in_meta_valid and in_meta_data.
REQ-017 SHALL discard any transferred entry whose pkt_flags == PKT_DROP: no write, counted in stats_drop_cnt.
REQ-018 SHALL write every other transferred entry, PKT_PCIE or any other flag value, unmodified at the write pointer, and count it in stats_pass_cnt.
REQ-019 SHALL be first-word-fall-through: out_meta_valid = (occupancy != 0); out_meta_data = entry at the read pointer, stable while out_meta_valid && !out_meta_ready.
REQ-020 SHALL present an entry written into an empty FIFO with out_meta_valid high in the cycle after its input transfer (latency 1).
REQ-021 SHALL advance read and write pointers modulo DEPTH, wrapping from DEPTH-1 to 0.
REQ-022 SHALL leave occupancy unchanged on a simultaneous write and pop, including at occupancy 1, and change it by +1 or -1 otherwise.
REQ-023 SHALL produce no write when full (ready low), and no pop and no pointer change when empty.
REQ-024 SHALL saturate both counters at all-ones.
REQ-025 SHALL give stats_clr priority over the increment in the same cycle: counter becomes 0.

Reset
REQ-026 SHALL, with rst low at a clock edge, set pointers and occupancy to 0, out_meta_valid to 0, and both counters to 0.
REQ-027 SHALL, on reset mid-operation, flush all stored entries; in_meta_ready is 1 in the first cycle after rst deasserts.
REQ-028 SHALL NOT require storage RAM contents to be reset.

Configuration
REQ-029 SHALL, with macro META_DROP_STATS_EN defined, implement the counters per REQ-017, REQ-018, REQ-024 and REQ-025.
REQ-030 SHALL, without META_DROP_STATS_EN, keep the ports, tie stats_pass_cnt and stats_drop_cnt to 0, ignore stats_clr, and leave the datapath unchanged.

Structure
REQ-031 SHALL take metadata_t, PKT_PCIE and PKT_DROP from the shared struct package; no local redefinition.
REQ-032 SHALL place the counter saturation and clear logic in one sub-module, sat_counter, instantiated twice.

Verification
REQ-033 Send 3 PKT_PCIE entries into an empty FIFO, out_meta_ready=1 -> each appears 1 cycle after input in order; pass=3, drop=0.
REQ-034 Send the pattern PCIE, DROP, PCIE, DROP (queue_id='1 on drops) -> only the 2 PCIE entries emerge; pass=2, drop=2; occupancy never exceeds 2.
REQ-035 Hold out_meta_ready=0 and push 16 PCIE entries -> occupancy=16 and in_meta_ready=0; a 17th valid is not accepted; releasing ready drains 16 entries in order.
REQ-036 Keep the FIFO at occupancy 1 with push and pop every cycle for 40 cycles -> occupancy stays 1, pointers wrap, data order preserved.
REQ-037 Preload drop_cnt to all-ones and send one DROP -> drop_cnt stays all-ones; assert stats_clr with a DROP in the same cycle -> drop_cnt=0.
REQ-038 Assert rst low at occupancy 5 -> the next cycle has out_meta_valid=0, occupancy=0 and counters 0; new entries flow normally after release.

Source files
------------

// File: rtl/meta_drop_fifo_pkg.sv
// Shared metadata definitions for the flow director to PCIe path.
// Provides the metadata struct, the packet flag encodings and a drop-check helper.
package meta_drop_fifo_pkg;

    typedef logic [1:0] pkt_flags_t;

    localparam pkt_flags_t PKT_PCIE = 2'd0;
    localparam pkt_flags_t PKT_DROP = 2'd1;

    typedef struct packed {
        logic [7:0]  queue_id;
        logic [15:0] flow_id;
        pkt_flags_t  pkt_flags;
    } metadata_t;

    function automatic logic isDrop(input metadata_t meta);
        return meta.pkt_flags == PKT_DROP;
    endfunction

endpackage

// File: rtl/meta_drop_fifo_sat_counter.sv
// sat_counter: statistics counter that sticks at all-ones instead of wrapping.
// A clear request wins over an increment arriving in the same cycle.
module sat_counter
    import meta_drop_fifo_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    // Clear has priority; otherwise count up until the value saturates at all-ones
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/meta_drop_fifo.sv
// meta_drop_fifo: first-word-fall-through metadata queue that discards entries
// flagged PKT_DROP before they are stored and forwards everything else in order.
// Optional statistics counters are built only when META_DROP_STATS_EN is defined;
// otherwise the statistic outputs read 0 and stats_clr has no effect.
module meta_drop_fifo
    import meta_drop_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  metadata_t                in_meta_data,
    input  logic                     in_meta_valid,
    output logic                     in_meta_ready,
    output metadata_t                out_meta_data,
    output logic                     out_meta_valid,
    input  logic                     out_meta_ready,
    output logic [$clog2(DEPTH):0]   occupancy,
    input  logic                     stats_clr,
    output logic [CNT_W-1:0]         stats_pass_cnt,
    output logic [CNT_W-1:0]         stats_drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    metadata_t   r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [OW-1:0] r_occ;

    logic w_inXfer;
    logic w_drop;
    logic w_write;
    logic w_pop;

    assign in_meta_ready  = (r_occ != OW'(DEPTH));
    assign out_meta_valid = (r_occ != '0);
    assign out_meta_data  = r_mem[r_rdPtr];
    assign occupancy      = r_occ;

    assign w_inXfer = in_meta_valid && in_meta_ready;
    assign w_drop   = isDrop(in_meta_data);
    assign w_write  = w_inXfer && !w_drop;
    assign w_pop    = out_meta_valid && out_meta_ready;

    // Storage is written without reset; only the pointers decide what is valid
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wrPtr] <= in_meta_data;
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy holds when a write and pop coincide
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_occ   <= '0;
        end else begin
            if (w_write) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            if (w_write && !w_pop) begin
                r_occ <= r_occ + OW'(1);
            end else if (w_pop && !w_write) begin
                r_occ <= r_occ - OW'(1);
            end
        end
    end

`ifdef META_DROP_STATS_EN
    logic w_dropInc;

    assign w_dropInc = w_inXfer && w_drop;

    sat_counter #(.W(CNT_W)) u_passCnt (
        .clk (clk),
        .rst (rst),
        .clr (stats_clr),
        .inc (w_write),
        .cnt (stats_pass_cnt)
    );

    sat_counter #(.W(CNT_W)) u_dropCnt (
        .clk (clk),
        .rst (rst),
        .clr (stats_clr),
        .inc (w_dropInc),
        .cnt (stats_drop_cnt)
    );
`else
    logic w_unused_stats_clr;

    assign w_unused_stats_clr = stats_clr;
    assign stats_pass_cnt     = '0;
    assign stats_drop_cnt     = '0;
`endif

endmodule

// File: tb/tb_meta_drop_fifo.sv
// tb_meta_drop_fifo: directed self-checking bench for meta_drop_fifo.
// Expected statistics follow META_DROP_STATS_EN: real counts when defined, 0 otherwise.
module tb_meta_drop_fifo;
    import meta_drop_fifo_pkg::*;

    localparam int DEPTH = 16;
    localparam int CNT_W = 4;

    logic                   clk;
    logic                   rst;
    metadata_t              in_meta_data;
    logic                   in_meta_valid;
    logic                   in_meta_ready;
    metadata_t              out_meta_data;
    logic                   out_meta_valid;
    logic                   out_meta_ready;
    logic [$clog2(DEPTH):0] occupancy;
    logic                   stats_clr;
    logic [CNT_W-1:0]       stats_pass_cnt;
    logic [CNT_W-1:0]       stats_drop_cnt;

    int totalChecks;
    int badChecks;

    meta_drop_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_meta_data   (in_meta_data),
        .in_meta_valid  (in_meta_valid),
        .in_meta_ready  (in_meta_ready),
        .out_meta_data  (out_meta_data),
        .out_meta_valid (out_meta_valid),
        .out_meta_ready (out_meta_ready),
        .occupancy      (occupancy),
        .stats_clr      (stats_clr),
        .stats_pass_cnt (stats_pass_cnt),
        .stats_drop_cnt (stats_drop_cnt)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic metadata_t mk(input logic [7:0] q, input logic [15:0] f, input pkt_flags_t fl);
        metadata_t m;
        m.queue_id  = q;
        m.flow_id   = f;
        m.pkt_flags = fl;
        return m;
    endfunction

    function automatic logic [CNT_W-1:0] expStat(input logic [CNT_W-1:0] v);
`ifdef META_DROP_STATS_EN
        return v;
`else
        return v & '0;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input metadata_t data);
        in_meta_valid = valid;
        in_meta_data  = data;
        tick();
        in_meta_valid = 1'b0;
    endtask

    task automatic checkStats(input string tag, input logic [CNT_W-1:0] passExp, input logic [CNT_W-1:0] dropExp);
        checkOutput({tag, "_pass"}, 64'(stats_pass_cnt), 64'(expStat(passExp)));
        checkOutput({tag, "_drop"}, 64'(stats_drop_cnt), 64'(expStat(dropExp)));
    endtask

    // Directed scenario sequence
    initial begin
        metadata_t e;
        totalChecks    = 0;
        badChecks      = 0;
        rst            = 1'b0;
        in_meta_data   = '0;
        in_meta_valid  = 1'b0;
        out_meta_ready = 1'b0;
        stats_clr      = 1'b0;

        tick();
        tick();
        checkOutput("rst_occ",   64'(occupancy), 64'd0);
        checkOutput("rst_valid", 64'(out_meta_valid), 64'd0);
        checkOutput("rst_ready", 64'(in_meta_ready), 64'd1);
        checkStats("rst", 4'd0, 4'd0);
        rst = 1'b1;
        tick();

        $display("[TB] three PCIE entries, latency 1");
        out_meta_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, mk(8'(i), 16'h0100 + 16'(i), PKT_PCIE));
            checkOutput("t1_valid", 64'(out_meta_valid), 64'd1);
            checkOutput("t1_data",  64'(out_meta_data), 64'(mk(8'(i), 16'h0100 + 16'(i), PKT_PCIE)));
            checkOutput("t1_occ",   64'(occupancy), 64'd1);
        end
        applyStimulus(1'b0, '0);
        checkOutput("t1_empty", 64'(out_meta_valid), 64'd0);
        checkStats("t1", 4'd3, 4'd0);

        $display("[TB] PCIE/DROP alternation");
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        checkStats("t2_clr", 4'd0, 4'd0);
        out_meta_ready = 1'b0;
        applyStimulus(1'b1, mk(8'h11, 16'h2001, PKT_PCIE));
        checkOutput("t2_occ0", 64'(occupancy), 64'd1);
        applyStimulus(1'b1, mk(8'hFF, 16'h2002, PKT_DROP));
        checkOutput("t2_occ1", 64'(occupancy), 64'd1);
        applyStimulus(1'b1, mk(8'h12, 16'h2003, PKT_PCIE));
        checkOutput("t2_occ2", 64'(occupancy), 64'd2);
        applyStimulus(1'b1, mk(8'hFF, 16'h2004, PKT_DROP));
        checkOutput("t2_occ3", 64'(occupancy), 64'd2);
        out_meta_ready = 1'b1;
        checkOutput("t2_head0", 64'(out_meta_data), 64'(mk(8'h11, 16'h2001, PKT_PCIE)));
        tick();
        checkOutput("t2_head1", 64'(out_meta_data), 64'(mk(8'h12, 16'h2003, PKT_PCIE)));
        tick();
        checkOutput("t2_empty", 64'(out_meta_valid), 64'd0);
        checkStats("t2", 4'd2, 4'd2);

        $display("[TB] fill to full with output stalled");
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        out_meta_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, mk(8'(i), 16'h1000 + 16'(i), PKT_PCIE));
        end
        checkOutput("t3_occ_full", 64'(occupancy), 64'd16);
        checkOutput("t3_ready_lo", 64'(in_meta_ready), 64'd0);
        checkOutput("t3_head_hold", 64'(out_meta_data), 64'(mk(8'd0, 16'h1000, PKT_PCIE)));
        applyStimulus(1'b1, mk(8'hEE, 16'hDEAD, PKT_PCIE));
        checkOutput("t3_occ_17", 64'(occupancy), 64'd16);
        checkStats("t3_sat", 4'd15, 4'd0);
        out_meta_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput("t3_drain", 64'(out_meta_data), 64'(mk(8'(i), 16'h1000 + 16'(i), PKT_PCIE)));
            tick();
        end
        checkOutput("t3_empty", 64'(out_meta_valid), 64'd0);
        checkOutput("t3_occ0",  64'(occupancy), 64'd0);

        $display("[TB] occupancy 1 streaming with wrap");
        applyStimulus(1'b1, mk(8'd0, 16'h4000, PKT_PCIE));
        for (int i = 1; i <= 40; i++) begin
            e = mk(8'(i), 16'h4000 + 16'(i), (i % 3 == 0) ? 2'd2 : PKT_PCIE);
            applyStimulus(1'b1, e);
            checkOutput("t4_occ",  64'(occupancy), 64'd1);
            checkOutput("t4_data", 64'(out_meta_data), 64'(e));
        end
        applyStimulus(1'b0, '0);
        checkOutput("t4_empty", 64'(out_meta_valid), 64'd0);
        checkStats("t4", 4'd15, 4'd0);

        $display("[TB] drop counter saturation and clear priority");
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b1, mk(8'hFF, 16'h5000 + 16'(i), PKT_DROP));
        end
        checkStats("t5_full", 4'd0, 4'd15);
        applyStimulus(1'b1, mk(8'hFF, 16'h5100, PKT_DROP));
        checkStats("t5_sat", 4'd0, 4'd15);
        checkOutput("t5_occ", 64'(occupancy), 64'd0);
        stats_clr = 1'b1;
        applyStimulus(1'b1, mk(8'hFF, 16'h5101, PKT_DROP));
        stats_clr = 1'b0;
        checkStats("t5_clr", 4'd0, 4'd0);

        $display("[TB] reset mid-operation");
        out_meta_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, mk(8'(i), 16'h6000 + 16'(i), PKT_PCIE));
        end
        checkOutput("t6_occ5", 64'(occupancy), 64'd5);
        checkStats("t6_pre", 4'd5, 4'd0);
        rst = 1'b0;
        tick();
        checkOutput("t6_valid", 64'(out_meta_valid), 64'd0);
        checkOutput("t6_occ",   64'(occupancy), 64'd0);
        checkStats("t6_rst", 4'd0, 4'd0);
        rst = 1'b1;
        checkOutput("t6_ready", 64'(in_meta_ready), 64'd1);
        applyStimulus(1'b1, mk(8'h77, 16'h7001, 2'd2));
        checkOutput("t6_new_valid", 64'(out_meta_valid), 64'd1);
        checkOutput("t6_new_data",  64'(out_meta_data), 64'(mk(8'h77, 16'h7001, 2'd2)));
        out_meta_ready = 1'b1;
        tick();
        checkOutput("t6_drained", 64'(out_meta_valid), 64'd0);
        checkStats("t6_post", 4'd1, 4'd0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
